spart_driver: RTL and testbench
===============================

SPART_DRIVER -- requirements
Module: spart_driver

Interface
REQ-001 SHALL have parameter DIV_4800, default 16'h0145, divisor loaded for br_cfg=00.
REQ-002 SHALL have parameter DIV_9600, default 16'h00A2, divisor loaded for br_cfg=01.
REQ-003 SHALL have parameter DIV_19200, default 16'h0051, divisor loaded for br_cfg=10.
REQ-004 SHALL have parameter DIV_38400, default 16'h0028, divisor loaded for br_cfg=11.
REQ-005 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port br_cfg  input  2  baud-rate select, quasi-static.
REQ-008 SHALL have port rda  input  1  SPART receive-data-available.
REQ-009 SHALL have port tbr  input  1  SPART transmit-buffer-ready.
REQ-010 SHALL have port iocs  output  1  SPART chip select.
REQ-011 SHALL have port iorw  output  1  1 = read, 0 = write.
REQ-012 SHALL have port ioaddr  output  2  00 TX/RX buffer, 01 status, 10 divisor low, 11 divisor high.
REQ-013 SHALL have port databus  inout  8  shared tri-state bus to SPART.
REQ-014 SHALL have port rx_char  output  8  last character read from SPART.
REQ-015 SHALL have port echo_cnt  output  8  count of characters echoed.
REQ-016 SHALL have port cfg_done  output  1  high once divisor programmed for current br_cfg.

Function
REQ-017 SHALL implement states CFG_LO, CFG_HI, IDLE, READ_RX, WAIT_TBR, WRITE_TX.
REQ-018 SHALL drive databus only when iocs=1 and iorw=0; otherwise databus SHALL be 8'bz.
REQ-019 SHALL, in IDLE and WAIT_TBR, drive iocs=0, iorw=1, ioaddr=00.
REQ-020 SHALL, in CFG_LO (one cycle), drive iocs=1, iorw=0, ioaddr=10, databus=selected divisor[7:0]; next state CFG_HI.
REQ-021 SHALL, in CFG_HI (one cycle), drive iocs=1, iorw=0, ioaddr=11, databus=divisor[15:8]; next state IDLE; cfg_done SHALL go 1 on that edge.
REQ-022 SHALL register br_cfg on entry to CFG_LO and select the divisor from the registered value for both CFG cycles.
REQ-023 SHALL, in IDLE, go to CFG_LO (cfg_done->0) when br_cfg differs from registered value; else go to READ_RX when rda=1; else stay.
REQ-024 SHALL give reconfiguration priority over rda when both occur in the same IDLE cycle.
REQ-025 SHALL, in READ_RX (one cycle), drive iocs=1, iorw=1, ioaddr=00, release databus, and load rx_char from databus at the ending edge; next state WAIT_TBR.
REQ-026 SHALL remain in WAIT_TBR while tbr=0 and go to WRITE_TX on the first cycle tbr=1.
REQ-027 SHALL, in WRITE_TX (one cycle), drive iocs=1, iorw=0, ioaddr=00, databus=rx_char; next state IDLE; echo_cnt SHALL increment on that edge.
REQ-028 SHALL wrap echo_cnt from 8'hFF to 8'h00.
REQ-029 SHALL ignore br_cfg changes during READ_RX/WAIT_TBR/WRITE_TX; change is acted on at next IDLE.
REQ-030 SHALL ignore rda outside IDLE; a character arriving during an echo is read on return to IDLE.
REQ-031 SHALL keep every bus access single-cycle; no bus output SHALL glitch mid-cycle (outputs decoded from registered state only).

Reset
REQ-032 SHALL, while rst=1, force state CFG_LO-pending: iocs=0, iorw=1, ioaddr=00, databus=z, rx_char=0, echo_cnt=0, cfg_done=0, registered br_cfg=00.
REQ-033 SHALL enter CFG_LO on the first clock edge after rst deasserts.
REQ-034 SHALL, on rst mid-transaction, abandon the access immediately (asynchronously) and reprogram the divisor after release.

Verification
REQ-035 Reset release with br_cfg=01 -> two cycles: (iocs1,iorw0,addr10,db A2), (iocs1,iorw0,addr11,db 00); cfg_done=1 after.
REQ-036 SPART model raises rda, returns 8'h67 on read, tbr=1 -> READ_RX, WAIT_TBR one cycle, WRITE_TX drives 8'h67 at addr 00; rx_char=67, echo_cnt=1.
REQ-037 tbr held 0 for 500 cycles after read of 8'h23 -> iocs=0 throughout; write of 8'h23 exactly one cycle after tbr rises.
REQ-038 br_cfg 01->11 while in WAIT_TBR -> echo completes, then CFG writes 8'h28, 8'h00; rda asserted same IDLE cycle serviced after CFG_HI.
REQ-039 256 echoes -> echo_cnt returns 8'h00; databus never driven during read cycles (no X contention).
REQ-040 rst pulse during WRITE_TX -> iocs=0 and databus=z within the same cycle; echo_cnt=0; full reconfiguration follows.

Source files
------------

// File: rtl/spart_driver.sv
// Host-side driver for a SPART UART: programs the baud divisor, then echoes every
// received character back out through the same tri-state register interface.
module spart_driver #(
  parameter logic [15:0] DIV_4800  = 16'h0145,
  parameter logic [15:0] DIV_9600  = 16'h00A2,
  parameter logic [15:0] DIV_19200 = 16'h0051,
  parameter logic [15:0] DIV_38400 = 16'h0028
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] br_cfg,
  input  logic       rda,
  input  logic       tbr,
  output logic       iocs,
  output logic       iorw,
  output logic [1:0] ioaddr,
  inout  wire  [7:0] databus,
  output logic [7:0] rx_char,
  output logic [7:0] echo_cnt,
  output logic       cfg_done
);

  localparam logic [2:0] ST_PEND     = 3'd0;
  localparam logic [2:0] ST_CFG_LO   = 3'd1;
  localparam logic [2:0] ST_CFG_HI   = 3'd2;
  localparam logic [2:0] ST_IDLE     = 3'd3;
  localparam logic [2:0] ST_READ_RX  = 3'd4;
  localparam logic [2:0] ST_WAIT_TBR = 3'd5;
  localparam logic [2:0] ST_WRITE_TX = 3'd6;

  localparam logic [1:0] ADDR_BUF    = 2'b00;
  localparam logic [1:0] ADDR_DIV_LO = 2'b10;
  localparam logic [1:0] ADDR_DIV_HI = 2'b11;

  logic [2:0]  state_q, state_d;
  logic [1:0]  brcfg_q, brcfg_d;
  logic        iocs_q, iocs_d;
  logic        iorw_q, iorw_d;
  logic [1:0]  ioaddr_q, ioaddr_d;
  logic [7:0]  dout_q, dout_d;
  logic [7:0]  rx_char_q, rx_char_d;
  logic [7:0]  echo_cnt_q, echo_cnt_d;
  logic        cfg_done_q, cfg_done_d;
  logic [15:0] div_sel;

  function automatic logic [15:0] sel_div(input logic [1:0] cfg);
    case (cfg)
      2'b00:   sel_div = DIV_4800;
      2'b01:   sel_div = DIV_9600;
      2'b10:   sel_div = DIV_19200;
      default: sel_div = DIV_38400;
    endcase
  endfunction

  // Next-state logic; bus outputs are then decoded from the next state so they
  // leave the flops cleanly on the same edge the state changes.
  always_comb begin
    state_d    = state_q;
    brcfg_d    = brcfg_q;
    rx_char_d  = rx_char_q;
    echo_cnt_d = echo_cnt_q;
    cfg_done_d = cfg_done_q;
    iocs_d     = 1'b0;
    iorw_d     = 1'b1;
    ioaddr_d   = ADDR_BUF;
    dout_d     = 8'h00;

    case (state_q)
      ST_PEND:   state_d = ST_CFG_LO;
      ST_CFG_LO: state_d = ST_CFG_HI;
      ST_CFG_HI: begin
        state_d    = ST_IDLE;
        cfg_done_d = 1'b1;
      end
      ST_IDLE: begin
        if (br_cfg != brcfg_q) begin
          state_d    = ST_CFG_LO;
          cfg_done_d = 1'b0;
        end else if (rda) begin
          state_d = ST_READ_RX;
        end
      end
      ST_READ_RX: begin
        state_d   = ST_WAIT_TBR;
        rx_char_d = databus;
      end
      ST_WAIT_TBR: if (tbr) state_d = ST_WRITE_TX;
      ST_WRITE_TX: begin
        state_d    = ST_IDLE;
        echo_cnt_d = echo_cnt_q + 8'd1;
      end
      default: state_d = ST_PEND;
    endcase

    // Capture br_cfg only when entering CFG_LO so both divisor bytes agree.
    if (state_d == ST_CFG_LO && state_q != ST_CFG_LO) brcfg_d = br_cfg;
    div_sel = sel_div(brcfg_d);

    case (state_d)
      ST_CFG_LO: begin
        iocs_d   = 1'b1;
        iorw_d   = 1'b0;
        ioaddr_d = ADDR_DIV_LO;
        dout_d   = div_sel[7:0];
      end
      ST_CFG_HI: begin
        iocs_d   = 1'b1;
        iorw_d   = 1'b0;
        ioaddr_d = ADDR_DIV_HI;
        dout_d   = div_sel[15:8];
      end
      ST_READ_RX: iocs_d = 1'b1;
      ST_WRITE_TX: begin
        iocs_d = 1'b1;
        iorw_d = 1'b0;
        dout_d = rx_char_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_PEND;
      brcfg_q    <= 2'b00;
      iocs_q     <= 1'b0;
      iorw_q     <= 1'b1;
      ioaddr_q   <= ADDR_BUF;
      dout_q     <= 8'h00;
      rx_char_q  <= 8'h00;
      echo_cnt_q <= 8'h00;
      cfg_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      brcfg_q    <= brcfg_d;
      iocs_q     <= iocs_d;
      iorw_q     <= iorw_d;
      ioaddr_q   <= ioaddr_d;
      dout_q     <= dout_d;
      rx_char_q  <= rx_char_d;
      echo_cnt_q <= echo_cnt_d;
      cfg_done_q <= cfg_done_d;
    end
  end

  assign databus  = (iocs_q && !iorw_q) ? dout_q : 8'bz;
  assign iocs     = iocs_q;
  assign iorw     = iorw_q;
  assign ioaddr   = ioaddr_q;
  assign rx_char  = rx_char_q;
  assign echo_cnt = echo_cnt_q;
  assign cfg_done = cfg_done_q;

endmodule

// File: tb/tb_spart_driver.sv
// Directed bench for spart_driver: a small SPART model answers reads, and a
// scoreboard queue holds every bus write the driver is expected to make.
module tb_spart_driver;

  typedef struct packed {
    logic [1:0] addr;
    logic [7:0] data;
  } wr_t;

  logic       clk;
  logic       rst;
  logic [1:0] br_cfg;
  logic       rda;
  logic       tbr;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  wire  [7:0] databus;
  logic [7:0] rx_char;
  logic [7:0] echo_cnt;
  logic       cfg_done;

  logic [7:0] spart_data;
  logic [7:0] exp_cnt;
  wr_t        sb_q[$];
  int         checks;
  int         failures;

  spart_driver dut (
    .clk      (clk),
    .rst      (rst),
    .br_cfg   (br_cfg),
    .rda      (rda),
    .tbr      (tbr),
    .iocs     (iocs),
    .iorw     (iorw),
    .ioaddr   (ioaddr),
    .databus  (databus),
    .rx_char  (rx_char),
    .echo_cnt (echo_cnt),
    .cfg_done (cfg_done)
  );

  // SPART model answers reads of the receive buffer.
  assign databus = (iocs && iorw && ioaddr == 2'b00) ? spart_data : 8'bz;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push_wr(input logic [1:0] a, input logic [7:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    sb_q.push_back(w);
  endtask

  // Write cycles are popped against the scoreboard; read cycles must see only the SPART.
  always @(negedge clk) begin
    if (iocs && !iorw) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_wr", 16'({ioaddr, databus}), 16'hFFFF);
      end else begin
        wr_t w;
        w = sb_q.pop_front();
        check("wr_addr", 16'(ioaddr), 16'(w.addr));
        check("wr_data", 16'(databus), 16'(w.data));
      end
    end else if (iocs && iorw) begin
      check("rd_bus", 16'(databus), 16'(spart_data));
    end
  end

  task automatic do_echo(input logic [7:0] d);
    spart_data = d;
    push_wr(2'b00, d);
    rda = 1'b1;
    tbr = 1'b1;
    tick();
    check("echo_rd", 16'({iocs, iorw, ioaddr}), 16'h000C);
    rda = 1'b0;
    tick();
    tick();
    check("echo_wr", 16'({iocs, iorw, ioaddr}), 16'h0008);
    tick();
    exp_cnt = exp_cnt + 8'd1;
    check("echo_cnt", 16'(echo_cnt), 16'(exp_cnt));
    check("echo_rx", 16'(rx_char), 16'(d));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int hi_cnt;
    checks     = 0;
    failures   = 0;
    exp_cnt    = 8'h00;
    clk        = 1'b0;
    rst        = 1'b1;
    br_cfg     = 2'b01;
    rda        = 1'b0;
    tbr        = 1'b0;
    spart_data = 8'h00;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_bus", 16'({iocs, iorw, ioaddr}), 16'h0004);
    check("rst_rx", 16'(rx_char), 16'h0000);
    check("rst_cnt", 16'(echo_cnt), 16'h0000);
    check("rst_cfg", 16'(cfg_done), 16'h0000);

    // Configuration at 9600 after release
    push_wr(2'b10, 8'hA2);
    push_wr(2'b11, 8'h00);
    rst = 1'b0;
    tick();
    check("cfg_lo_cyc", 16'({iocs, iorw, ioaddr}), 16'h000A);
    check("cfg_done_lo", 16'(cfg_done), 16'h0000);
    tick();
    check("cfg_hi_cyc", 16'({iocs, iorw, ioaddr}), 16'h000B);
    tick();
    check("cfg_done_set", 16'(cfg_done), 16'h0001);
    check("idle_bus", 16'({iocs, iorw, ioaddr}), 16'h0004);

    // Basic echo of 0x67
    do_echo(8'h67);

    // tbr held low for 500 cycles
    spart_data = 8'h23;
    push_wr(2'b00, 8'h23);
    rda = 1'b1;
    tbr = 1'b0;
    tick();
    rda = 1'b0;
    hi_cnt = 0;
    repeat (500) begin
      tick();
      if (iocs) hi_cnt++;
    end
    check("wait_quiet", 16'(hi_cnt), 16'h0000);
    tbr = 1'b1;
    tick();
    check("wait_release", 16'({iocs, iorw, ioaddr}), 16'h0008);
    tick();
    exp_cnt = exp_cnt + 8'd1;
    check("cnt_after_wait", 16'(echo_cnt), 16'(exp_cnt));

    // br_cfg change during WAIT_TBR, plus rda in the same IDLE cycle
    spart_data = 8'h5A;
    push_wr(2'b00, 8'h5A);
    rda = 1'b1;
    tbr = 1'b0;
    tick();
    rda = 1'b0;
    tick();
    br_cfg = 2'b11;
    tbr = 1'b1;
    tick();
    check("wr_despite_cfg", 16'({iocs, iorw, ioaddr}), 16'h0008);
    spart_data = 8'h3C;
    rda = 1'b1;
    push_wr(2'b10, 8'h28);
    push_wr(2'b11, 8'h00);
    push_wr(2'b00, 8'h3C);
    tick();
    exp_cnt = exp_cnt + 8'd1;
    check("idle_before_cfg", 16'({iocs, cfg_done}), 16'h0001);
    tick();
    check("cfg_priority", 16'({iocs, iorw, ioaddr}), 16'h000A);
    check("cfg_done_clr", 16'(cfg_done), 16'h0000);
    tick();
    tick();
    check("cfg_done_38400", 16'(cfg_done), 16'h0001);
    tick();
    check("rda_after_cfg", 16'({iocs, iorw, ioaddr}), 16'h000C);
    rda = 1'b0;
    tick();
    tick();
    tick();
    exp_cnt = exp_cnt + 8'd1;
    check("cnt_after_cfg", 16'(echo_cnt), 16'(exp_cnt));

    // Wrap of echo_cnt back to zero
    while (exp_cnt != 8'h00) do_echo(8'($urandom_range(255)));
    check("cnt_wrap", 16'(echo_cnt), 16'h0000);

    // Reset mid-write, then reprogram at 19200
    spart_data = 8'h99;
    push_wr(2'b00, 8'h99);
    rda = 1'b1;
    tbr = 1'b1;
    tick();
    rda = 1'b0;
    tick();
    tick();
    check("pre_rst_wr", 16'({iocs, iorw}), 16'h0002);
    #1 rst = 1'b1;
    br_cfg = 2'b10;
    #1;
    check("rst_async_bus", 16'({iocs, iorw, ioaddr}), 16'h0004);
    check("rst_async_cnt", 16'(echo_cnt), 16'h0000);
    check("rst_async_cfg", 16'(cfg_done), 16'h0000);
    exp_cnt = 8'h00;
    @(negedge clk);
    @(negedge clk);
    push_wr(2'b10, 8'h51);
    push_wr(2'b11, 8'h00);
    rst = 1'b0;
    tick();
    check("recfg_lo", 16'({iocs, iorw, ioaddr}), 16'h000A);
    tick();
    tick();
    check("recfg_done", 16'(cfg_done), 16'h0001);
    do_echo(8'hC3);

    check("sb_drain", 16'(sb_q.size()), 16'h0000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
